// File: rtl/redmule_tile_ifetch_axi_master.sv
// Instruction-fetch OBI-to-AXI4 read initiator: single-beat reads, bounded outstanding, in-order responses.
// Optional REDMULE_TILE_IFETCH_ALIGN_CHECK_EN: misaligned fetches answered locally with an error.
package redmule_tile_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } core_instr_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } core_instr_rsp_t;
endpackage

module redmule_tile_ifetch_axi_master #(
    parameter int unsigned ADDR_W          = redmule_tile_pkg::ADDR_W,
    parameter int unsigned DATA_W          = redmule_tile_pkg::DATA_W,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              instr_req_i,
    input  logic [ADDR_W-1:0]                 instr_addr_i,
    output logic                              instr_gnt_o,
    output logic                              instr_rvalid_o,
    output logic [31:0]                       instr_rdata_o,
    output logic                              instr_err_o,
    output redmule_tile_pkg::core_instr_req_t axi_req_o,
    input  redmule_tile_pkg::core_instr_rsp_t axi_rsp_i
);
    localparam int unsigned NLANES = DATA_W / 32;
    localparam int unsigned LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic              ar_valid_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [LANE_W-1:0] lane_fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_nxt, rd_ptr_nxt;
    logic              rvalid_q, err_q;
    logic [31:0]       rdata_q;

    logic              slot_free, room, gnt_axi, gnt_mis, r_accept;
    logic [LANE_W-1:0] lane_in, lane_head;

    assign slot_free = !ar_valid_q || axi_rsp_i.ar_ready;
    assign room      = cnt_q < CNT_W'(MAX_OUTSTANDING);
    assign r_accept  = axi_rsp_i.r_valid && (cnt_q != '0);
    assign lane_in   = LANE_W'((instr_addr_i >> 2) % NLANES);
    assign lane_head = lane_fifo_q[rd_ptr_q];

`ifdef REDMULE_TILE_IFETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |instr_addr_i[1:0];
    assign gnt_axi    = instr_req_i && !misaligned && slot_free && room;
    // Local error answers only when the AXI side is fully idle, keeping responses in order.
    assign gnt_mis    = instr_req_i && misaligned && (cnt_q == '0) && !ar_valid_q;
`else
    assign gnt_axi    = instr_req_i && slot_free && room;
    assign gnt_mis    = 1'b0;
`endif

    assign instr_gnt_o    = gnt_axi || gnt_mis;
    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;

    assign wr_ptr_nxt = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_nxt = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) lane_fifo_q[i] <= '0;
        end else begin
            if (gnt_axi) begin
                ar_valid_q <= 1'b1;
                ar_addr_q  <= {instr_addr_i[ADDR_W-1:2], 2'b00};
                lane_fifo_q[wr_ptr_q] <= lane_in;
                wr_ptr_q   <= wr_ptr_nxt;
            end else if (axi_rsp_i.ar_ready) begin
                ar_valid_q <= 1'b0;
            end
            if (r_accept) rd_ptr_q <= rd_ptr_nxt;
            case ({gnt_axi, r_accept})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            rvalid_q <= r_accept || gnt_mis;
            if (r_accept) begin
                rdata_q <= axi_rsp_i.r.data[32*lane_head +: 32];
                err_q   <= axi_rsp_i.r.resp[1];
            end else if (gnt_mis) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        axi_req_o             = '0;
        axi_req_o.ar.addr     = ar_addr_q;
        axi_req_o.ar.size     = 3'd2;
        axi_req_o.ar.burst    = 2'b01;
        axi_req_o.ar.prot     = 3'b100;
        axi_req_o.ar_valid    = ar_valid_q;
        axi_req_o.b_ready     = 1'b1;
        axi_req_o.r_ready     = 1'b1;
    end

    logic unused_rsp;
    assign unused_rsp = ^{axi_rsp_i.aw_ready, axi_rsp_i.w_ready, axi_rsp_i.b, axi_rsp_i.b_valid,
                          axi_rsp_i.r.resp[0], axi_rsp_i.r.last, axi_rsp_i.r.id, instr_addr_i[1:0]};

`ifndef SYNTHESIS
    a_r_without_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_rsp_i.r_valid |-> cnt_q != '0);
    a_r_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_rsp_i.r_valid |-> axi_rsp_i.r.last);
    a_r_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        axi_rsp_i.r_valid |-> axi_rsp_i.r.id == '0);
`endif
endmodule

// File: tb/tb_redmule_tile_ifetch_axi_master.sv
// Randomized bench for the fetch AXI master: transaction-level model plus AXI slave responder.
module tb_redmule_tile_ifetch_axi_master;
    import redmule_tile_pkg::*;

    localparam int MAXO = 2;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            instr_req_i;
    logic [31:0]     instr_addr_i;
    logic            instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]     instr_rdata_o;
    core_instr_req_t axi_req_o;
    core_instr_rsp_t axi_rsp_i;

    redmule_tile_ifetch_axi_master #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .axi_req_o(axi_req_o), .axi_rsp_i(axi_rsp_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory contents seen by the responder, one 32-bit word per aligned address.
    function automatic logic [31:0] word(logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h104) return 32'h11223344;
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic bit is_err(logic [31:0] a);
        return a[15:12] == 4'hE;
    endfunction

    typedef struct { logic [31:0] addr; int due; } rsp_e;

    int          m_cnt, cyc, max_dly, fix_dly;
    bit          m_arp;
    logic [31:0] m_araddr, m_reqaddr;
    rsp_e        rq[$];
    bit          pend_rv, pend_err, last_err, exp_gnt;
    logic [31:0] pend_data, last_data;

    task automatic clear_model();
        m_cnt = 0; m_arp = 0; rq.delete();
        pend_rv = 0; last_data = '0; last_err = 0;
    endtask

    task automatic cycle(bit req, logic [31:0] addr, bit arr);
        logic [31:0] base;
        rsp_e e;
        bit mis;
        @(negedge clk_i);
        if (pend_rv) begin
            check("rvalid", instr_rvalid_o, 1);
            last_data = pend_data; last_err = pend_err;
        end else begin
            check("rvalid_idle", instr_rvalid_o, 0);
        end
        check("rdata", instr_rdata_o, last_data);
        check("err", instr_err_o, last_err);
        pend_rv = 0;
        check("ar_valid", axi_req_o.ar_valid, m_arp);
        if (m_arp) begin
            check("ar_addr", axi_req_o.ar.addr, m_araddr);
            check("ar_fields", {axi_req_o.ar.id, axi_req_o.ar.len, axi_req_o.ar.size, axi_req_o.ar.burst,
                                axi_req_o.ar.lock, axi_req_o.ar.cache, axi_req_o.ar.prot},
                  {4'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'b100});
        end
        check("static_ch", {axi_req_o.aw_valid, axi_req_o.w_valid, axi_req_o.b_ready, axi_req_o.r_ready}, 4'b0011);

        instr_req_i = req; instr_addr_i = addr; axi_rsp_i.ar_ready = arr;
        axi_rsp_i.r.id = '0; axi_rsp_i.r.last = 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            base = rq[0].addr & ~32'h7;
            axi_rsp_i.r_valid = 1'b1;
            axi_rsp_i.r.data  = {word(base + 4), word(base)};
            axi_rsp_i.r.resp  = is_err(rq[0].addr) ? 2'b10 : 2'b00;
        end else begin
            axi_rsp_i.r_valid = 1'b0;
            axi_rsp_i.r.data  = {$urandom, $urandom};
            axi_rsp_i.r.resp  = 2'($urandom);
        end
        #1;
`ifdef REDMULE_TILE_IFETCH_ALIGN_CHECK_EN
        mis = addr[1:0] != 2'b00;
        exp_gnt = req && (mis ? (m_cnt == 0 && !m_arp) : ((!m_arp || arr) && m_cnt < MAXO));
`else
        mis = 0;
        exp_gnt = req && (!m_arp || arr) && m_cnt < MAXO;
`endif
        check("gnt", instr_gnt_o, exp_gnt);
        if (m_arp && arr) begin
            e.addr = m_reqaddr;
            e.due  = cyc + 1 + ((fix_dly >= 0) ? fix_dly : int'($urandom_range(0, max_dly)));
            rq.push_back(e);
            m_arp = 0;
        end
        if (axi_rsp_i.r_valid) begin
            e = rq.pop_front();
            pend_rv = 1; pend_data = word(e.addr & ~32'h3); pend_err = is_err(e.addr);
            m_cnt--;
        end
        if (exp_gnt) begin
            if (mis) begin
                pend_rv = 1; pend_data = '0; pend_err = 1;
            end else begin
                m_arp = 1; m_araddr = addr & ~32'h3; m_reqaddr = addr; m_cnt++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        instr_req_i = 0; axi_rsp_i.r_valid = 0; axi_rsp_i.ar_ready = 0;
        clear_model();
        #1;
        check("rst_rvalid", instr_rvalid_o, 0);
        check("rst_rdata", instr_rdata_o, 0);
        check("rst_err", instr_err_o, 0);
        check("rst_ar_valid", axi_req_o.ar_valid, 0);
        check("rst_gnt", instr_gnt_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic fetch(logic [31:0] addr, bit arr);
        int k = 0;
        do begin
            cycle(1, addr, arr);
            k++;
        end while (!exp_gnt && k < 40);
        if (!exp_gnt) check("fetch_timeout", 1, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 32'h0, 1);
    endtask

    initial begin
        logic [31:0] a;
        int req_pct, arr_pct, k;
        axi_rsp_i = '0; instr_req_i = 0; instr_addr_i = '0;
        cyc = 0; max_dly = 0; fix_dly = 0;
        clear_model();
        do_reset();

        fetch(32'h100, 1); idle(6);
        fix_dly = 5;
        fetch(32'h100, 1); fetch(32'h104, 1); fetch(32'h1010, 1); fetch(32'h1014, 1);
        idle(16);
        fix_dly = 0;
        fetch(32'h100, 1); fetch(32'hE000, 1); idle(6);
        fetch(32'h104, 1); idle(6);
        fetch(32'h200, 0); cycle(1, 32'h204, 0); cycle(1, 32'h204, 0); cycle(1, 32'h204, 0);
        fetch(32'h204, 1); idle(8);
        fetch(32'h102, 1); idle(6);

        fix_dly = -1; max_dly = 3; req_pct = 70; arr_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                req_pct = $urandom_range(20, 100);
                arr_pct = $urandom_range(20, 100);
                max_dly = $urandom_range(0, 6);
            end
            if (i == 1500) do_reset();
            a = 32'h1000 + ($urandom & 32'h0FFF);
            if ($urandom_range(0, 9) == 0) a[15:12] = 4'hE;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            cycle($urandom_range(1, 100) <= req_pct, a, $urandom_range(1, 100) <= arr_pct);
        end

        k = 0;
        while ((rq.size() > 0 || m_arp || pend_rv) && k < 200) begin
            cycle(0, 32'h0, 1);
            k++;
        end
        if (k >= 200) check("drain_timeout", 1, 0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
